// File: rtl/ro_puf_sequencer.sv
// RO PUF measurement sequencer: 16 rounds of 256 cycles, one oscillator pair per round,
// edge-count compare per round. Optional PUF_TIE_FLAG_EN adds the per-round Tie output.
module ro_puf_sequencer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [0:15] RO_A,
  input  logic [0:15] RO_B,
  output logic [0:15] Ro_en,
  output logic        Out_bit,
  output logic [0:3]  round,
  output logic [0:7]  count,
  output logic        Busy,
`ifdef PUF_TIE_FLAG_EN
  output logic [0:15] Tie,
`endif
  output logic        Done
);

  localparam logic [3:0]       ROUND_LAST = 4'd15;
  localparam logic [7:0]       COUNT_LAST = 8'd255;
  localparam logic [7:0]       WIN_LO     = 8'd4;
  localparam logic [7:0]       WIN_HI     = 8'd247;
  localparam logic [7:0]       CMP_AT     = 8'd249;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             sa_s1, sa_s2, sa_d;
  logic             sb_s1, sb_s2, sb_d;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  logic ro_a_sel, ro_b_sel, edge_a, edge_b, in_win, last_cyc;

  // One-hot enable vector for a given round index
  function automatic logic [0:15] onehot(input logic [3:0] r);
    logic [0:15] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  assign ro_a_sel = RO_A[round];
  assign ro_b_sel = RO_B[round];
  assign edge_a   = sa_s2 & ~sa_d;
  assign edge_b   = sb_s2 & ~sb_d;
  assign in_win   = (count >= WIN_LO) && (count <= WIN_HI);
  assign last_cyc = (round == ROUND_LAST) && (count == COUNT_LAST);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      round   <= ROUND_LAST;
      count   <= COUNT_LAST;
      Ro_en   <= '0;
      Out_bit <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      sa_s1   <= 1'b0;
      sa_s2   <= 1'b0;
      sa_d    <= 1'b0;
      sb_s1   <= 1'b0;
      sb_s2   <= 1'b0;
      sb_d    <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
`ifdef PUF_TIE_FLAG_EN
      Tie     <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= RUN;
            round   <= 4'd0;
            count   <= 8'd0;
            Busy    <= 1'b1;
            Ro_en   <= onehot(4'd0);
            sa_s1   <= 1'b0;
            sa_s2   <= 1'b0;
            sa_d    <= 1'b0;
            sb_s1   <= 1'b0;
            sb_s2   <= 1'b0;
            sb_d    <= 1'b0;
            cnt_a   <= '0;
            cnt_b   <= '0;
`ifdef PUF_TIE_FLAG_EN
            Tie     <= '0;
`endif
          end
        end

        RUN: begin
          // Sequencing: round/count advance, park values are already in place on exit
          if (last_cyc) begin
            state_q <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Ro_en   <= '0;
          end else begin
            count <= count + 8'd1;
            if (count == COUNT_LAST) begin
              round <= round + 4'd1;
              Ro_en <= onehot(round + 4'd1);
            end
          end

          // Synchronizers, edge detectors and counters restart with each pair
          if (count == 8'd0) begin
            sa_s1 <= 1'b0;
            sa_s2 <= 1'b0;
            sa_d  <= 1'b0;
            sb_s1 <= 1'b0;
            sb_s2 <= 1'b0;
            sb_d  <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
          end else begin
            sa_s1 <= ro_a_sel;
            sa_s2 <= sa_s1;
            sa_d  <= sa_s2;
            sb_s1 <= ro_b_sel;
            sb_s2 <= sb_s1;
            sb_d  <= sb_s2;
            if (edge_a && in_win && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
            if (edge_b && in_win && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
          end

          if (count == CMP_AT) begin
            Out_bit    <= (cnt_a > cnt_b);
`ifdef PUF_TIE_FLAG_EN
            Tie[round] <= (cnt_a == cnt_b);
`endif
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
          Ro_en   <= '0;
          round   <= ROUND_LAST;
          count   <= COUNT_LAST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer: timing, response patterns, saturation, ties, reset abort.
module tb_ro_puf_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b1;
  logic start   = 1'b0;
  logic start_s = 1'b0;
  int   mode    = 0;

  // Free-running oscillators, phase-offset from clk: clk/6, clk/10, clk/3
  logic w6 = 1'b0, w10 = 1'b0, w3 = 1'b0;
  initial begin #3; forever #30 w6 = ~w6; end
  initial begin #7; forever #50 w10 = ~w10; end
  initial begin #1; forever #15 w3 = ~w3; end

  logic [0:15] ro_a, ro_b, ro_a_s, ro_b_s;
  always_comb begin
    ro_a = '0;
    ro_b = '0;
    for (int r = 0; r < 16; r++) begin
      case (mode)
        1:       begin ro_a[r] = (r % 2 == 0) ? w6 : w10; ro_b[r] = (r % 2 == 0) ? w10 : w6; end
        2:       begin ro_a[r] = w6; ro_b[r] = w6; end
        default: begin ro_a[r] = w6; ro_b[r] = w10; end
      endcase
    end
    ro_a_s = {16{w3}};
    ro_b_s = '0;
  end

  logic [0:15] ro_en, ro_en_s;
  logic        out_bit, out_bit_s, busy, busy_s, done, done_s;
  logic [0:3]  rnd, rnd_s;
  logic [0:7]  cnt, cnt_s;
`ifdef PUF_TIE_FLAG_EN
  logic [0:15] tie, tie_s;
`endif

  ro_puf_sequencer #(.CNT_W(12)) dut (
    .clk(clk), .Reset_n(rst_n), .Start(start), .RO_A(ro_a), .RO_B(ro_b),
    .Ro_en(ro_en), .Out_bit(out_bit), .round(rnd), .count(cnt), .Busy(busy),
`ifdef PUF_TIE_FLAG_EN
    .Tie(tie),
`endif
    .Done(done)
  );

  ro_puf_sequencer #(.CNT_W(4)) dut_s (
    .clk(clk), .Reset_n(rst_n), .Start(start_s), .RO_A(ro_a_s), .RO_B(ro_b_s),
    .Ro_en(ro_en_s), .Out_bit(out_bit_s), .round(rnd_s), .count(cnt_s), .Busy(busy_s),
`ifdef PUF_TIE_FLAG_EN
    .Tie(tie_s),
`endif
    .Done(done_s)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one-hot enables, response capture at count 250, Done pulse counts
  logic [0:15] resp = '0;
  int onehot_bad = 0, done_cnt = 0, done_cnt_s = 0;
  always @(negedge clk) begin
    logic [0:15] e;
    e = '0;
    if (busy) e[rnd] = 1'b1;
    if (ro_en !== e) onehot_bad++;
    if (busy && cnt == 8'd0 && rnd == 4'd0) resp = '0;
    if (busy && cnt == 8'd250) resp[rnd] = out_bit;
    if (done) done_cnt++;
    if (done_s) done_cnt_s++;
  end

  task automatic run_full(input int m, input logic [15:0] exp_resp, input bit with_small);
    int d0;
    logic [0:15] er;
    er = exp_resp;
    d0 = done_cnt;
    mode = m;
    start = 1'b1;
    if (with_small) start_s = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_T1", 32'(busy), 32'd1);
    chk("round_T1", 32'(rnd), 32'd0);
    chk("count_T1", 32'(cnt), 32'd0);
    chk("ro_en_T1", 32'(ro_en), 32'h8000);
    repeat (249) @(posedge clk); #1;
    if (with_small) chk("sat_cnt_a", 32'(dut_s.cnt_a), 32'd15);
    @(posedge clk); #1;
    chk("out_bit_r0", 32'(out_bit), 32'(er[0]));
    if (with_small) chk("out_bit_small", 32'(out_bit_s), 32'd1);
    repeat (3845) @(posedge clk); #1;
    chk("done_early", 32'(done), 32'd0);
    chk("busy_last", 32'(busy), 32'd1);
    chk("round_last", 32'(rnd), 32'd15);
    chk("count_last", 32'(cnt), 32'd255);
    if (with_small) begin
      chk("small_busy_held", 32'(busy_s), 32'd1);
      chk("small_count_last", 32'(cnt_s), 32'd255);
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("ro_en_done", 32'(ro_en), 32'd0);
    chk("round_park", 32'(rnd), 32'd15);
    chk("count_park", 32'(cnt), 32'd255);
    start_s = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("response", 32'(resp), 32'(exp_resp));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (20) @(posedge clk); #1;
    chk("idle_round", 32'(rnd), 32'd15);
    chk("idle_count", 32'(cnt), 32'd255);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ro_en", 32'(ro_en), 32'd0);
    chk("idle_out_bit", 32'(out_bit), 32'd0);
    chk("idle_no_done", 32'(done_cnt), 32'd0);

    // A faster everywhere; small instance with Start held and saturating counter
    run_full(0, 16'hFFFF, 1'b1);
    repeat (5) @(posedge clk); #1;
    chk("small_one_done", 32'(done_cnt_s), 32'd1);
    chk("small_idle", 32'(busy_s), 32'd0);

    // Alternating faster side
    run_full(1, 16'hAAAA, 1'b0);
    chk("onehot_track", 32'(onehot_bad), 32'd0);

    // Identical stimulus on both sides
    run_full(2, 16'h0000, 1'b0);
`ifdef PUF_TIE_FLAG_EN
    chk("tie_all", 32'(tie), 32'hFFFF);
`endif

    // Second start clears Tie; abort with reset at round 7 / count 100
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
`ifdef PUF_TIE_FLAG_EN
    chk("tie_cleared", 32'(tie), 32'd0);
`endif
    repeat (1892) @(posedge clk); #1;
    chk("pre_rst_round", 32'(rnd), 32'd7);
    chk("pre_rst_count", 32'(cnt), 32'd100);
    chk("pre_rst_out_bit", 32'(out_bit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_round", 32'(rnd), 32'd15);
    chk("rst_count", 32'(cnt), 32'd255);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_out_bit", 32'(out_bit), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full measurement after the aborted one
    run_full(0, 16'hFFFF, 1'b0);
    chk("onehot_final", 32'(onehot_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
